// File: rtl/uart_cmd_sequencer.sv
// UART command sequencer: pops RX bytes, optionally echoes them to TX, and decodes
// single-byte commands plus H/M/S two-digit time-set transactions.
module uart_cmd_sequencer #(
  parameter bit          ECHO_EN        = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] rx_data,
  output logic       rx_pop,
  input  logic       tx_full,
  output logic       tx_push,
  output logic [7:0] tx_data,
  output logic       cmd_run,
  output logic       cmd_clear,
  output logic       cmd_mode,
  output logic       cmd_sel,
  output logic       cmd_dump,
  output logic       led_en,
  output logic [1:0] app_sel,
  output logic       set_valid,
  output logic [1:0] set_field,
  output logic [6:0] set_value,
  output logic       err
);
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ECHO = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;

  localparam logic [1:0] P_CMD  = 2'd0;
  localparam logic [1:0] P_DIG1 = 2'd1;
  localparam logic [1:0] P_DIG2 = 2'd2;

  localparam logic [7:0] CH_RUN   = 8'h72;
  localparam logic [7:0] CH_CLEAR = 8'h63;
  localparam logic [7:0] CH_MODE  = 8'h6D;
  localparam logic [7:0] CH_SEL   = 8'h73;
  localparam logic [7:0] CH_DUMP  = 8'h40;
  localparam logic [7:0] CH_LED   = 8'h4C;
  localparam logic [7:0] CH_ONE   = 8'h31;
  localparam logic [7:0] CH_TWO   = 8'h32;
  localparam logic [7:0] CH_THREE = 8'h33;
  localparam logic [7:0] CH_HOUR  = 8'h48;
  localparam logic [7:0] CH_MIN   = 8'h4D;
  localparam logic [7:0] CH_SEC   = 8'h53;
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;

  logic [1:0]    state_q, state_d;
  logic [1:0]    phase_q, phase_d;
  logic [7:0]    byte_q, byte_d;
  logic [3:0]    tens_q, tens_d;
  logic [1:0]    field_q, field_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          run_q, run_d, clear_q, clear_d, mode_q, mode_d;
  logic          sel_q, sel_d, dump_q, dump_d;
  logic          set_valid_q, set_valid_d, err_q, err_d, led_q, led_d;
  logic [1:0]    app_sel_q, app_sel_d, set_field_q, set_field_d;
  logic [6:0]    set_value_q, set_value_d;

  logic       is_digit;
  logic [6:0] value;
  logic       in_range;

  // ASCII digits have their numeric value in the low nibble.
  assign is_digit = (byte_q >= 8'h30) && (byte_q <= 8'h39);
  assign value    = ({3'b000, tens_q} * 7'd10) + {3'b000, byte_q[3:0]};
  assign in_range = (field_q == 2'd2) ? (value < 7'd24) : (value < 7'd60);

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    byte_d      = byte_q;
    tens_d      = tens_q;
    field_d     = field_q;
    timer_d     = timer_q;
    led_d       = led_q;
    app_sel_d   = app_sel_q;
    set_field_d = set_field_q;
    set_value_d = set_value_q;
    run_d       = 1'b0;
    clear_d     = 1'b0;
    mode_d      = 1'b0;
    sel_d       = 1'b0;
    dump_d      = 1'b0;
    set_valid_d = 1'b0;
    err_d       = 1'b0;
    rx_pop      = 1'b0;
    tx_push     = 1'b0;

    if (phase_q == P_CMD) timer_d = '0;

    case (state_q)
      S_IDLE: begin
        if (!rx_empty) begin
          rx_pop  = 1'b1;
          byte_d  = rx_data;
          timer_d = '0;
          state_d = ECHO_EN ? S_ECHO : S_EXEC;
        end else if (phase_q != P_CMD) begin
          // Inter-byte timeout only matters while a set transaction is open.
          if (timer_q == T_LAST) begin
            err_d   = 1'b1;
            phase_d = P_CMD;
            timer_d = '0;
          end else begin
            timer_d = timer_q + TW'(1);
          end
        end
      end
      S_ECHO: begin
        if (!tx_full) begin
          tx_push = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = S_IDLE;
        case (phase_q)
          P_CMD: begin
            case (byte_q)
              CH_RUN:   run_d   = 1'b1;
              CH_CLEAR: clear_d = 1'b1;
              CH_MODE:  mode_d  = 1'b1;
              CH_SEL:   sel_d   = 1'b1;
              CH_DUMP:  dump_d  = 1'b1;
              CH_LED:   led_d   = !led_q;
              CH_ONE, CH_TWO, CH_THREE: app_sel_d = byte_q[1:0];
              CH_HOUR: begin field_d = 2'd2; phase_d = P_DIG1; end
              CH_MIN:  begin field_d = 2'd1; phase_d = P_DIG1; end
              CH_SEC:  begin field_d = 2'd0; phase_d = P_DIG1; end
              CH_CR, CH_LF: begin end
              default: err_d = 1'b1;
            endcase
          end
          P_DIG1: begin
            if (is_digit) begin
              tens_d  = byte_q[3:0];
              phase_d = P_DIG2;
            end else begin
              err_d   = 1'b1;
              phase_d = P_CMD;
            end
          end
          P_DIG2: begin
            phase_d = P_CMD;
            if (is_digit && in_range) begin
              set_valid_d = 1'b1;
              set_field_d = field_q;
              set_value_d = value;
            end else begin
              err_d = 1'b1;
            end
          end
          default: phase_d = P_CMD;
        endcase
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      phase_q     <= P_CMD;
      byte_q      <= 8'h00;
      tens_q      <= 4'd0;
      field_q     <= 2'd0;
      timer_q     <= '0;
      run_q       <= 1'b0;
      clear_q     <= 1'b0;
      mode_q      <= 1'b0;
      sel_q       <= 1'b0;
      dump_q      <= 1'b0;
      set_valid_q <= 1'b0;
      err_q       <= 1'b0;
      led_q       <= 1'b0;
      app_sel_q   <= 2'd1;
      set_field_q <= 2'd0;
      set_value_q <= 7'd0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      byte_q      <= byte_d;
      tens_q      <= tens_d;
      field_q     <= field_d;
      timer_q     <= timer_d;
      run_q       <= run_d;
      clear_q     <= clear_d;
      mode_q      <= mode_d;
      sel_q       <= sel_d;
      dump_q      <= dump_d;
      set_valid_q <= set_valid_d;
      err_q       <= err_d;
      led_q       <= led_d;
      app_sel_q   <= app_sel_d;
      set_field_q <= set_field_d;
      set_value_q <= set_value_d;
    end
  end

  assign tx_data   = byte_q;
  assign cmd_run   = run_q;
  assign cmd_clear = clear_q;
  assign cmd_mode  = mode_q;
  assign cmd_sel   = sel_q;
  assign cmd_dump  = dump_q;
  assign led_en    = led_q;
  assign app_sel   = app_sel_q;
  assign set_valid = set_valid_q;
  assign set_field = set_field_q;
  assign set_value = set_value_q;
  assign err       = err_q;

endmodule

// File: tb/tb_uart_cmd_sequencer.sv
// Self-checking bench for uart_cmd_sequencer: transaction-level reference model
// compared every cycle, directed scenarios with literal expectations, random traffic.
module tb_uart_cmd_sequencer;
  localparam bit ECHO = 1'b1;
  localparam int TMO  = 20;

  localparam int RUN = 0, CLR = 1, MOD = 2, SEL = 3, DMP = 4, SETV = 5, ERR = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_empty;
  logic [7:0] rx_data;
  logic       rx_pop;
  logic       tx_full;
  logic       tx_push;
  logic [7:0] tx_data;
  logic       cmd_run, cmd_clear, cmd_mode, cmd_sel, cmd_dump;
  logic       led_en;
  logic [1:0] app_sel;
  logic       set_valid;
  logic [1:0] set_field;
  logic [6:0] set_value;
  logic       err;

  always #5 clk = ~clk;

  uart_cmd_sequencer #(.ECHO_EN(ECHO), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .rx_data(rx_data), .rx_pop(rx_pop),
    .tx_full(tx_full), .tx_push(tx_push), .tx_data(tx_data),
    .cmd_run(cmd_run), .cmd_clear(cmd_clear), .cmd_mode(cmd_mode), .cmd_sel(cmd_sel),
    .cmd_dump(cmd_dump), .led_en(led_en), .app_sel(app_sel), .set_valid(set_valid),
    .set_field(set_field), .set_value(set_value), .err(err)
  );

  int checks = 0;
  int failures = 0;

  // RX FIFO contents and stimulus knobs
  logic [7:0] rxq[$];
  bit rx_hold = 1'b1;
  bit full_force = 1'b0;
  bit full_rand = 1'b0;

  // Reference model: timing in absolute cycle numbers, parser in plain ints
  int cyc = 0;
  bit m_pending = 1'b0;
  bit m_pushed = 1'b0;
  logic [7:0] m_byte = 8'h00;
  logic [7:0] m_last = 8'h00;
  int m_vis = -1;
  int m_err_at = -1;
  bit m_led = 1'b0;
  int m_app = 1;
  int m_phase = 0;
  int m_tens = 0;
  int m_field = 0;
  int m_val = 0;
  int m_tcnt = 0;

  // Observed-event logs (cycle numbers / values) for literal checks
  int pop_log[$];
  int echo_log[$];
  int run_log[$];
  int clear_log[$];
  int dump_log[$];
  int err_log[$];
  int set_log[$];
  int led_rise_log[$];
  bit prev_led = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0d expected=%0d", name, cyc, act, exp);
    end
  endtask

  task automatic clear_logs();
    pop_log.delete(); echo_log.delete(); run_log.delete(); clear_log.delete();
    dump_log.delete(); err_log.delete(); set_log.delete(); led_rise_log.delete();
  endtask

  task automatic model_reset();
    m_pending = 1'b0; m_pushed = 1'b0; m_last = 8'h00; m_vis = -1; m_err_at = -1;
    m_led = 1'b0; m_app = 1; m_phase = 0; m_tens = 0; m_field = 0; m_tcnt = 0;
    prev_led = 1'b0;
  endtask

  // Byte meaning from the command rules; returns expected pulse vector.
  task automatic decode(input logic [7:0] b, output logic [6:0] p);
    bit dig;
    int d;
    p = '0;
    dig = (b >= 8'h30) && (b <= 8'h39);
    d = int'(b) - 48;
    if (m_phase == 0) begin
      case (b)
        8'h72: p[RUN] = 1'b1;
        8'h63: p[CLR] = 1'b1;
        8'h6D: p[MOD] = 1'b1;
        8'h73: p[SEL] = 1'b1;
        8'h40: p[DMP] = 1'b1;
        8'h4C: m_led = !m_led;
        8'h31, 8'h32, 8'h33: m_app = d;
        8'h48: begin m_field = 2; m_phase = 1; end
        8'h4D: begin m_field = 1; m_phase = 1; end
        8'h53: begin m_field = 0; m_phase = 1; end
        8'h0D, 8'h0A: begin end
        default: p[ERR] = 1'b1;
      endcase
    end else if (m_phase == 1) begin
      if (dig) begin m_tens = d; m_phase = 2; end
      else begin p[ERR] = 1'b1; m_phase = 0; end
    end else begin
      m_phase = 0;
      if (dig && (m_tens * 10 + d) < ((m_field == 2) ? 24 : 60)) begin
        p[SETV] = 1'b1;
        m_val = m_tens * 10 + d;
      end else begin
        p[ERR] = 1'b1;
      end
    end
  endtask

  task automatic step();
    logic [6:0] ep;
    logic [6:0] ap;
    bit exp_pop;
    bit exp_push;
    @(negedge clk);
    rx_empty = rx_hold || (rxq.size() == 0);
    rx_data  = (rxq.size() != 0) ? rxq[0] : 8'h00;
    tx_full  = full_force || (full_rand && ($urandom_range(0, 3) == 0));
    #1;
    ep = '0;
    if (m_pending && cyc == m_vis) begin
      decode(m_byte, ep);
      m_pending = 1'b0;
    end
    if (cyc == m_err_at) ep[ERR] = 1'b1;

    exp_push = ECHO && m_pending && !m_pushed && !tx_full;
    chk("tx_push", int'(tx_push), int'(exp_push));
    if (exp_push) begin m_pushed = 1'b1; m_vis = cyc + 2; end

    exp_pop = !m_pending && !rx_empty;
    chk("rx_pop", int'(rx_pop), int'(exp_pop));

    ap = {err, set_valid, cmd_dump, cmd_sel, cmd_mode, cmd_clear, cmd_run};
    chk("pulses", int'(ap), int'(ep));
    chk("led_en", int'(led_en), int'(m_led));
    chk("app_sel", int'(app_sel), m_app);
    chk("tx_data", int'(tx_data), int'(m_last));
    if (ep[SETV]) begin
      chk("set_field", int'(set_field), m_field);
      chk("set_value", int'(set_value), m_val);
    end

    if (rx_pop) pop_log.push_back(cyc);
    if (tx_push) echo_log.push_back(int'(tx_data));
    if (cmd_run) run_log.push_back(cyc);
    if (cmd_clear) clear_log.push_back(cyc);
    if (cmd_dump) dump_log.push_back(cyc);
    if (err) err_log.push_back(cyc);
    if (set_valid) set_log.push_back(int'(set_field) * 100 + int'(set_value));
    if (led_en && !prev_led) led_rise_log.push_back(cyc);
    prev_led = led_en;

    if (exp_pop) begin
      m_byte = rxq.pop_front();
      m_last = m_byte;
      m_pending = 1'b1;
      m_pushed = 1'b0;
      m_tcnt = 0;
      m_vis = ECHO ? -1 : cyc + 2;
    end else if (!m_pending && m_phase != 0) begin
      if (rx_empty) begin
        if (m_tcnt == TMO - 1) begin
          m_err_at = cyc + 1;
          m_phase = 0;
          m_tcnt = 0;
        end else begin
          m_tcnt++;
        end
      end
    end else begin
      m_tcnt = 0;
    end
    cyc++;
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      rst = 1'b0;
      rx_empty = 1'b1;
      tx_full = 1'b0;
      #1;
      chk("rst_rx_pop", int'(rx_pop), 0);
      chk("rst_tx_push", int'(tx_push), 0);
      chk("rst_tx_data", int'(tx_data), 0);
      chk("rst_pulses", int'({err, set_valid, cmd_dump, cmd_sel, cmd_mode, cmd_clear, cmd_run}), 0);
      chk("rst_led_en", int'(led_en), 0);
      chk("rst_app_sel", int'(app_sel), 1);
      chk("rst_set_field", int'(set_field), 0);
      chk("rst_set_value", int'(set_value), 0);
      cyc++;
    end
    model_reset();
    rst = 1'b1;
  endtask

  task automatic push_str(input string s);
    for (int i = 0; i < s.len(); i++) rxq.push_back(8'(s.getc(i)));
  endtask

  task automatic drain(input int budget);
    int n = 0;
    rx_hold = 1'b0;
    while ((rxq.size() != 0 || m_pending) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk("drain_budget", n, -1);
    repeat (2) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog cyc=%0d actual=running expected=finished", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    string pool;
    int n;
    int drop_cyc;
    int hold_left;
    rst = 1'b0;
    rx_empty = 1'b1;
    rx_data = 8'h00;
    tx_full = 1'b0;

    // Reset, then no pop while the FIFO reads empty
    do_reset(3);
    rx_hold = 1'b1;
    push_str("rLL2@");
    repeat (5) step();
    chk("no_pop_while_empty", pop_log.size(), 0);

    // Single commands
    drain(200);
    chk("t1_pop_count", pop_log.size(), 5);
    for (int i = 0; i < 4; i++) chk("t1_pop_spacing", pop_log[i+1] - pop_log[i], 3);
    chk("t1_echo_count", echo_log.size(), 5);
    chk("t1_echo0", echo_log[0], 'h72);
    chk("t1_echo1", echo_log[1], 'h4C);
    chk("t1_echo2", echo_log[2], 'h4C);
    chk("t1_echo3", echo_log[3], 'h32);
    chk("t1_echo4", echo_log[4], 'h40);
    chk("t1_run_lat", run_log[0] - pop_log[0], 3);
    chk("t1_led_rise_lat", led_rise_log[0] - pop_log[1], 3);
    chk("t1_led_final", int'(led_en), 0);
    chk("t1_app_sel", int'(app_sel), 2);
    chk("t1_dump_lat", dump_log[0] - pop_log[4], 3);

    // Time-set transactions
    clear_logs();
    push_str("H23M60S07");
    drain(300);
    chk("t2_set_count", set_log.size(), 2);
    chk("t2_set_hour23", set_log[0], 223);
    chk("t2_set_sec07", set_log[1], 7);
    chk("t2_err_count", err_log.size(), 1);
    chk("t2_app_sel_kept", int'(app_sel), 2);

    // Parse errors and ignored line endings
    clear_logs();
    push_str("Hxrq");
    rxq.push_back(8'h0D);
    drain(200);
    chk("t3_err_count", err_log.size(), 2);
    chk("t3_run_count", run_log.size(), 1);
    chk("t3_echo_count", echo_log.size(), 5);
    chk("t3_echo_cr", echo_log[4], 'h0D);
    chk("t3_set_count", set_log.size(), 0);

    // Inter-byte timeout
    clear_logs();
    push_str("S");
    drain(50);
    repeat (30) step();
    chk("t4_err_once", err_log.size(), 1);
    chk("t4_err_lat", err_log[0] - pop_log[0], 3 + TMO);
    push_str("5");
    drain(50);
    chk("t4_err_after_5", err_log.size(), 2);
    chk("t4_app_sel_kept", int'(app_sel), 2);

    // TX backpressure
    clear_logs();
    push_str("cr");
    rx_hold = 1'b0;
    n = 0;
    while (pop_log.size() == 0 && n < 20) begin step(); n++; end
    chk("t5_first_pop", pop_log.size(), 1);
    full_force = 1'b1;
    repeat (10) step();
    chk("t5_no_pop_stall", pop_log.size(), 1);
    chk("t5_no_push_stall", echo_log.size(), 0);
    full_force = 1'b0;
    drop_cyc = cyc;
    drain(100);
    chk("t5_clear_count", clear_log.size(), 1);
    chk("t5_clear_lat", clear_log[0] - drop_cyc, 2);
    chk("t5_pop_count", pop_log.size(), 2);
    chk("t5_echo_r", echo_log[1], 'h72);

    // Reset in the middle of a set transaction
    clear_logs();
    push_str("H2");
    rx_hold = 1'b0;
    n = 0;
    while (pop_log.size() < 2 && n < 20) begin step(); n++; end
    step();
    do_reset(2);
    rx_hold = 1'b1;
    clear_logs();
    push_str("3r");
    repeat (4) step();
    chk("t6_no_pop_after_rst", pop_log.size(), 0);
    drain(100);
    chk("t6_set_count", set_log.size(), 0);
    chk("t6_app_sel", int'(app_sel), 3);
    chk("t6_run_count", run_log.size(), 1);
    chk("t6_led_reset", int'(led_en), 0);

    // Random traffic with random TX backpressure and RX gaps
    pool = "rcms@L123HMS0123456789xq\r\nHH2M5S";
    full_rand = 1'b1;
    hold_left = 0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 9) < 3) rxq.push_back(8'(pool.getc($urandom_range(0, pool.len() - 1))));
      if ($urandom_range(0, 59) == 0) hold_left = 25;
      rx_hold = (hold_left > 0) || ($urandom_range(0, 4) == 0);
      if (hold_left > 0) hold_left--;
      step();
    end
    full_rand = 1'b0;
    drain(2000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_cmd_sequencer.md
# uart_cmd_sequencer

Sequencer between the UART RX/TX FIFOs and the watch/sensor application logic. Pops bytes from the RX FIFO one at a time, optionally echoes each to the TX FIFO, and decodes them into single-cycle command pulses, level controls and two-digit time-set transactions (`H`/`M`/`S` followed by two ASCII digits). Flow control is explicit: a byte is consumed only when the sequencer is ready, and echo stalls on TX full.

## Interface
- `ECHO_EN`, default 1: 1 echoes every popped byte to TX, 0 skips the ECHO state.
- `TIMEOUT_CYCLES`, default 100_000_000: idle cycles allowed between bytes of a set transaction, minimum 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `rx_empty` in 1: RX FIFO empty.
- `rx_data` in 8: RX FIFO head, first-word-fall-through, valid while `rx_empty`=0.
- `rx_pop` out 1: combinational pop strobe.
- `tx_full` in 1: TX FIFO full.
- `tx_push` out 1: combinational push strobe.
- `tx_data` out 8: echo byte, registered.
- `cmd_run`, `cmd_clear`, `cmd_mode`, `cmd_sel`, `cmd_dump` out 1 each: one-cycle pulses for `r`, `c`, `m`, `s`, `@`.
- `led_en` out 1: level, toggled by `L`.
- `app_sel` out 2: level, set to 1/2/3 by `1`/`2`/`3`.
- `set_valid` out 1: one-cycle pulse, time-set accepted.
- `set_field` out 2: 2=hour, 1=minute, 0=second; valid with `set_valid`.
- `set_value` out 7: binary value 0..59; valid with `set_valid`.
- `err` out 1: one-cycle pulse for a parse error or timeout.

## Operation
- FSM states:
  - IDLE: `rx_pop`=!`rx_empty`. On pop, latch `rx_data` into `tx_data`/byte register and go to ECHO, or to EXEC if `ECHO_EN`=0.
  - ECHO: `tx_push`=!`tx_full`. Go to EXEC on push; hold while full.
  - EXEC: decode the latched byte, update registered outputs, return to IDLE.
- Parse phase register, separate from the FSM: CMD, DIG1, DIG2.
- Phase CMD:
  - `r c m s @`: the matching pulse.
  - `L`: toggle `led_en`.
  - `1 2 3`: write `app_sel`.
  - `H M S`: store field, go to DIG1.
  - 0x0D/0x0A: silently ignored.
  - Any other byte: `err`.
- Phase DIG1: `0`–`9` stores tens, go to DIG2. A non-digit gives `err` and phase CMD; the byte is not reinterpreted as a command.
- Phase DIG2: a digit computes `value = tens*10 + ones`, using a 7-bit result.
  - Range check: hour <24, min/sec <60.
  - In range: `set_valid` with field/value. Out of range or non-digit: `err`.
  - Phase returns to CMD either way.
- Digits in DIG1/DIG2 never affect `app_sel`.
- Timeout timer:
  - Counts cycles in IDLE while phase≠CMD and `rx_empty`=1. Cleared on every pop and whenever phase=CMD.
  - On reaching `TIMEOUT_CYCLES`-1 with `rx_empty`=1: `err`, phase CMD.
  - If a byte is present that cycle, the pop wins and the timer clears.
- Reset values: `rx_pop`/`tx_push`=0, `tx_data`=0x00, all pulses 0, `led_en`=0, `app_sel`=2'd1, `set_field`=0, `set_value`=0, state IDLE, phase CMD, timer 0.
- Reset mid-transaction discards the partial set and any pending echo.

## Timing
- Byte present at edge N, in IDLE: `rx_pop` high in cycle N.
- With `ECHO_EN`=1, `tx_full`=0:
  - `tx_push` in cycle N+1.
  - Decode pulses and level changes visible in cycle N+3, for exactly one cycle.
  - Next pop possible in N+3.
- With `ECHO_EN`=0: outputs in N+2, next pop in N+2.
- `tx_full` stall of k cycles delays every later event by k.
- At most one of `cmd_*`/`set_valid`/`err` asserts per byte.
- Pulses never persist past one cycle, even with back-to-back bytes.
- `rx_pop` never asserts outside IDLE or when `rx_empty`=1.
- `tx_push` never asserts when `tx_full`=1.

## Test plan
- Reset: hold `rst`=0 mid-stream. All outputs equal their reset values, `app_sel`=1. After release, no pop occurs until `rx_empty`=0.
- Single commands, `ECHO_EN`=1: bytes `r`,`L`,`L`,`2`,`@`. Pops spaced 3 cycles; echoed bytes 0x72,0x4C,0x4C,0x32,0x40 in order; `cmd_run` pulse; `led_en` 0→1→0; `app_sel`=2; `cmd_dump` pulse, each at pop+3.
- Time set: `H`,`2`,`3` gives `set_valid` with field=2, value=23. `M`,`6`,`0` gives `err` and no `set_valid`. `S`,`0`,`7` gives field=0, value=7.
- Parse errors: `H`,`x` gives `err`, phase CMD; a following `r` gives `cmd_run`. Byte `q` gives `err`. 0x0D gives no pulse but is still echoed.
- Timeout with `TIMEOUT_CYCLES`=20: send `S`, wait 30 cycles. `err` fires exactly once. A following `5` sets `app_sel` unchanged and gives `err`, because `5` is unknown in CMD.
- Backpressure: hold `tx_full`=1 for 10 cycles after a pop of `c`. No `tx_push` and no further pop during the stall. `cmd_clear` appears 2 cycles after `tx_full` drops, and the RX FIFO contents are preserved.
